// File: rtl/clint_vec_pkg.sv
// clint_vec_pkg: shared trap FSM encoding and CSR field constants for clint_vec.
package clint_vec_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SAV, S_EPC, S_CAUSE, S_AINT, S_RET, S_ARET} state_t;
  localparam int MSTATUS_MIE_BIT = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [2:0] INT_WE_MSTATUS = 3'b001;
  localparam logic [2:0] INT_WE_MEPC = 3'b010;
  localparam logic [2:0] INT_WE_MCAUSE = 3'b100;
  function automatic int mcause_int_bit(input int data_w);
    return data_w - 1;
  endfunction
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder with valid flag.
module int_prio_enc #(
  parameter int N = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) if (i_req[i]) o_idx = IDX_W'(i);
  end
endmodule

// File: rtl/clint_vec.sv
// clint_vec: multi-channel core-local interrupt controller with edge latching,
// fixed priority, sequenced CSR save, mret handling and vectored trap targets.
module clint_vec
  import clint_vec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int INT_N = 8,
  parameter int VECTORED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INT_N-1:0]  int_req,
  input  logic [INT_N-1:0]  int_en,
  input  logic              global_int_en,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [DATA_W-1:0] csr_mtvec,
  input  logic [DATA_W-1:0] csr_mepc,
  input  logic [DATA_W-1:0] csr_mstatus,
  output logic              hold_flag_int,
  output logic [2:0]        int_we,
  output logic [DATA_W-1:0] int_mstatus,
  output logic [DATA_W-1:0] int_mepc,
  output logic [DATA_W-1:0] int_mcause,
  output logic              int_assert,
  output logic [ADDR_W-1:0] int_inst_addr,
  output logic [INT_N-1:0]  int_pending
);
  localparam int IDX_W = INT_N > 1 ? $clog2(INT_N) : 1;
  localparam int MC_BIT = mcause_int_bit(DATA_W);
  state_t r_state;
  logic [INT_N-1:0] r_req_q, r_pending;
  logic [IDX_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_epc, r_inst_addr;
  logic [2:0] r_we;
  logic [DATA_W-1:0] r_mstatus, r_mepc, r_mcause;
  logic r_assert;
  logic w_valid, w_take;
  logic [IDX_W-1:0] w_idx;
  logic [INT_N-1:0] w_edge, w_clr;
  logic [DATA_W-1:0] w_sav_ms, w_ret_ms, w_mcause;
  logic [ADDR_W-1:0] w_base, w_target;
  int_prio_enc #(.N(INT_N), .IDX_W(IDX_W)) u_enc (
    .i_req(r_pending & int_en),
    .o_valid(w_valid),
    .o_idx(w_idx)
  );
  assign w_edge = int_req & ~r_req_q;
  assign w_take = (r_state == S_IDLE) && !ret_req && global_int_en && w_valid;
  assign w_clr = w_take ? INT_N'(1) << w_idx : '0;
  assign w_mcause = DATA_W'(r_idx) | (DATA_W'(1) << MC_BIT);
  assign w_base = ADDR_W'(csr_mtvec & ~DATA_W'(3));
  assign w_target = (VECTORED != 0 && csr_mtvec[0]) ? w_base + ADDR_W'({r_idx, 2'b00}) : w_base;
  always_comb begin
    w_sav_ms = csr_mstatus;
    w_sav_ms[MSTATUS_MPIE_BIT] = csr_mstatus[MSTATUS_MIE_BIT];
    w_sav_ms[MSTATUS_MIE_BIT] = 1'b0;
    w_ret_ms = csr_mstatus;
    w_ret_ms[MSTATUS_MIE_BIT] = csr_mstatus[MSTATUS_MPIE_BIT];
    w_ret_ms[MSTATUS_MPIE_BIT] = 1'b1;
  end
  // Outputs are computed on the transition so they are valid throughout each state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req_q <= '0;
      r_pending <= '0;
      r_idx <= '0;
      r_epc <= '0;
      r_we <= '0;
      r_mstatus <= '0;
      r_mepc <= '0;
      r_mcause <= '0;
      r_assert <= 1'b0;
      r_inst_addr <= '0;
    end else begin
      r_req_q <= int_req;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_we <= '0;
      r_assert <= 1'b0;
      case (r_state)
        S_IDLE:
          if (ret_req) begin
            r_state <= S_RET;
            r_we <= INT_WE_MSTATUS;
            r_mstatus <= w_ret_ms;
          end else if (w_take) begin
            r_state <= S_SAV;
            r_we <= INT_WE_MSTATUS;
            r_mstatus <= w_sav_ms;
            r_idx <= w_idx;
            r_epc <= jump_flag ? jump_addr : inst_addr;
          end
        S_SAV: begin
          r_state <= S_EPC;
          r_we <= INT_WE_MEPC;
          r_mepc <= DATA_W'(r_epc);
        end
        S_EPC: begin
          r_state <= S_CAUSE;
          r_we <= INT_WE_MCAUSE;
          r_mcause <= w_mcause;
        end
        S_CAUSE: begin
          r_state <= S_AINT;
          r_assert <= 1'b1;
          r_inst_addr <= w_target;
        end
        S_RET: begin
          r_state <= S_ARET;
          r_assert <= 1'b1;
          r_inst_addr <= ADDR_W'(csr_mepc);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign hold_flag_int = r_state inside {S_SAV, S_EPC, S_CAUSE, S_RET};
  assign int_we = r_we;
  assign int_mstatus = r_mstatus;
  assign int_mepc = r_mepc;
  assign int_mcause = r_mcause;
  assign int_assert = r_assert;
  assign int_inst_addr = r_inst_addr;
  assign int_pending = r_pending;
endmodule

// File: tb/tb_clint_vec.sv
// tb_clint_vec: directed self-checking bench for clint_vec with hand-computed expectations.
module tb_clint_vec;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] int_req, int_en, int_pending;
  logic global_int_en, ret_req, jump_flag, hold_flag_int, int_assert;
  logic [15:0] inst_addr, jump_addr, csr_mtvec, csr_mepc, csr_mstatus;
  logic [15:0] int_mstatus, int_mepc, int_mcause, int_inst_addr;
  logic [2:0] int_we;
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  clint_vec #(.DATA_W(16), .ADDR_W(16), .INT_N(8), .VECTORED(1)) dut (
    .clk(clk), .rst_n(rst_n), .int_req(int_req), .int_en(int_en),
    .global_int_en(global_int_en), .ret_req(ret_req), .inst_addr(inst_addr),
    .jump_flag(jump_flag), .jump_addr(jump_addr), .csr_mtvec(csr_mtvec),
    .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus), .hold_flag_int(hold_flag_int),
    .int_we(int_we), .int_mstatus(int_mstatus), .int_mepc(int_mepc),
    .int_mcause(int_mcause), .int_assert(int_assert), .int_inst_addr(int_inst_addr),
    .int_pending(int_pending)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst_n = 1'b0; int_req = '0; int_en = '0; global_int_en = 1'b0; ret_req = 1'b0;
    inst_addr = '0; jump_flag = 1'b0; jump_addr = '0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
    step(); step();
    chk("rst_hold", hold_flag_int, 0);
    chk("rst_we", int_we, 0);
    chk("rst_assert", int_assert, 0);
    chk("rst_pending", int_pending, 0);
    chk("rst_addr", int_inst_addr, 0);
    rst_n = 1'b1; int_en = 8'hFF; global_int_en = 1'b1;
    csr_mtvec = 16'h0101; inst_addr = 16'h0040; csr_mstatus = 16'h0008;
    step();
    // single interrupt on channel 5, vectored target
    int_req = 8'h20;
    step();
    chk("t1_pend", int_pending, 8'h20);
    chk("t1_hold_idle", hold_flag_int, 0);
    step();
    chk("t1_we0", int_we, 3'b001);
    chk("t1_mstatus", int_mstatus, 16'h0080);
    chk("t1_hold0", hold_flag_int, 1);
    chk("t1_pend_clr", int_pending, 0);
    step();
    chk("t1_we1", int_we, 3'b010);
    chk("t1_mepc", int_mepc, 16'h0040);
    chk("t1_hold1", hold_flag_int, 1);
    step();
    chk("t1_we2", int_we, 3'b100);
    chk("t1_mcause", int_mcause, 16'h8005);
    chk("t1_hold2", hold_flag_int, 1);
    step();
    chk("t1_assert", int_assert, 1);
    chk("t1_target", int_inst_addr, 16'h0114);
    chk("t1_hold3", hold_flag_int, 0);
    chk("t1_we3", int_we, 0);
    int_req = 8'h00;
    step();
    chk("t1_assert_end", int_assert, 0);
    // simultaneous edges on channels 2 and 6
    int_req = 8'h44;
    step();
    chk("t2_pend", int_pending, 8'h44);
    step();
    chk("t2_we0", int_we, 3'b001);
    chk("t2_pend_after", int_pending, 8'h40);
    step(); step();
    chk("t2_mcause_a", int_mcause, 16'h8002);
    step();
    chk("t2_target_a", int_inst_addr, 16'h0108);
    step();
    chk("t2_idle_we", int_we, 0);
    chk("t2_idle_hold", hold_flag_int, 0);
    step();
    chk("t2_we_b", int_we, 3'b001);
    chk("t2_pend_b", int_pending, 0);
    step(); step();
    chk("t2_mcause_b", int_mcause, 16'h8006);
    step();
    chk("t2_target_b", int_inst_addr, 16'h0118);
    int_req = 8'h00;
    step();
    // jump redirect captured as epc, direct mode
    csr_mtvec = 16'h0100; jump_flag = 1'b1; jump_addr = 16'h0200; int_req = 8'h80;
    step(); step();
    chk("t3_we0", int_we, 3'b001);
    jump_flag = 1'b0;
    step();
    chk("t3_mepc", int_mepc, 16'h0200);
    step();
    chk("t3_mcause", int_mcause, 16'h8007);
    step();
    chk("t3_target", int_inst_addr, 16'h0100);
    chk("t3_assert", int_assert, 1);
    int_req = 8'h00;
    step();
    // globally disabled, then channel-masked, then enabled
    global_int_en = 1'b0; int_req = 8'h08;
    step(); step(); step();
    chk("t4_gie_we", int_we, 0);
    chk("t4_gie_pend", int_pending, 8'h08);
    global_int_en = 1'b1; int_en = 8'hF7;
    step(); step();
    chk("t4_mask_we", int_we, 0);
    chk("t4_mask_pend", int_pending, 8'h08);
    chk("t4_mask_hold", hold_flag_int, 0);
    int_en = 8'hFF;
    step();
    chk("t4_we0", int_we, 3'b001);
    step(); step();
    chk("t4_mcause", int_mcause, 16'h8003);
    step();
    chk("t4_target", int_inst_addr, 16'h0100);
    step(); step(); step(); step();
    chk("t4_held_pend", int_pending, 0);
    chk("t4_held_we", int_we, 0);
    chk("t4_held_hold", hold_flag_int, 0);
    // mret and interrupt in the same idle cycle, then reset mid-sequence
    csr_mstatus = 16'h0080; csr_mepc = 16'h0044; int_req = 8'h0A;
    step();
    chk("t5_pend", int_pending, 8'h02);
    ret_req = 1'b1;
    step();
    ret_req = 1'b0;
    chk("t5_ret_we", int_we, 3'b001);
    chk("t5_ret_ms", int_mstatus, 16'h0088);
    chk("t5_ret_hold", hold_flag_int, 1);
    chk("t5_ret_pend", int_pending, 8'h02);
    step();
    chk("t5_ret_assert", int_assert, 1);
    chk("t5_ret_addr", int_inst_addr, 16'h0044);
    chk("t5_ret_hold2", hold_flag_int, 0);
    step();
    chk("t5_idle_we", int_we, 0);
    step();
    chk("t5_int_we", int_we, 3'b001);
    chk("t5_int_ms", int_mstatus, 16'h0000);
    int_req = 8'h12;
    step();
    chk("t5_epc_we", int_we, 3'b010);
    chk("t5_busy_pend", int_pending, 8'h10);
    rst_n = 1'b0; int_req = 8'h00;
    step();
    chk("t6_we", int_we, 0);
    chk("t6_assert", int_assert, 0);
    chk("t6_hold", hold_flag_int, 0);
    chk("t6_pend", int_pending, 0);
    chk("t6_mepc", int_mepc, 0);
    chk("t6_mcause", int_mcause, 0);
    rst_n = 1'b1;
    step(); step(); step();
    chk("t6_post_we", int_we, 0);
    chk("t6_post_assert", int_assert, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clint_vec.md
Name: clint_vec

Overview:
- Parametrised successor to the single-source core-local interrupt controller.
- Latches up to INT_N edge-triggered interrupt requests and masks them per channel.
- Picks the winner by fixed priority and runs a multi-cycle CSR save sequence (mstatus, mepc, mcause) while holding the pipeline, then redirects fetch to a direct or vectored trap target.
- Also sequences mret. Sits beside the CSR file and ctrl; replaces the existing controller.

Parameters:
- DATA_W, 16, CSR/data width (>= 8).
- ADDR_W, 16, instruction address width.
- INT_N, 8, number of interrupt channels (1..16).
- VECTORED, 1, 1 = honour mtvec[0] vectored mode; 0 = always direct.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous reset, active-low.
- int_req  in  INT_N  raw interrupt lines, one per channel.
- int_en  in  INT_N  per-channel enable mask (mie equivalent).
- global_int_en  in  1  mstatus.MIE from the CSR file.
- ret_req  in  1  one-cycle pulse: mret currently in EX.
- inst_addr  in  ADDR_W  current fetch PC.
- jump_flag  in  1  EX redirect this cycle.
- jump_addr  in  ADDR_W  EX redirect target.
- csr_mtvec  in  DATA_W  mtvec.
- csr_mepc  in  DATA_W  mepc.
- csr_mstatus  in  DATA_W  mstatus.
- hold_flag_int  out  1  pipeline hold request.
- int_we  out  3  one-hot CSR write strobe: [0] mstatus, [1] mepc, [2] mcause.
- int_mstatus  out  DATA_W  mstatus write data.
- int_mepc  out  DATA_W  mepc write data.
- int_mcause  out  DATA_W  mcause write data.
- int_assert  out  1  one-cycle redirect pulse.
- int_inst_addr  out  ADDR_W  redirect target.
- int_pending  out  INT_N  pending register, for debug/CSR read.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; pending=0; int_req history=0; all outputs 0.
- Edge detection: int_req is registered. Pending bit i sets on a 0->1 edge of int_req[i]. Pending bit i clears in the cycle channel i is accepted. If a new edge arrives on the same bit in that cycle, set wins.
- Eligible = pending & int_en. Winner = lowest eligible index (priority 0 highest).
- Interrupt is taken only in IDLE with global_int_en=1 and eligible != 0.
- Acceptance is registered. On acceptance the block captures:
  - idx = winner.
  - epc = jump_flag ? jump_addr : inst_addr.
  - status = csr_mstatus.
- Trap FSM, one state per cycle:
  - IDLE: if ret_req -> RET_ST (ret_req has priority over an interrupt in the same cycle); else if take -> SAV_ST.
  - SAV_ST: int_we=001; int_mstatus = status with bit7 (MPIE) = status[3] and bit3 (MIE) = 0. -> SAV_EPC.
  - SAV_EPC: int_we=010; int_mepc = zero-extended epc. -> SAV_CAUSE.
  - SAV_CAUSE: int_we=100; int_mcause = {1'b1, zeros, idx} (MSB set = interrupt). -> ASSERT_INT.
  - ASSERT_INT: int_assert=1; int_inst_addr = target. -> IDLE.
  - RET_ST: int_we=001; int_mstatus = csr_mstatus with bit3 = bit7 and bit7 = 1. -> ASSERT_RET.
  - ASSERT_RET: int_assert=1; int_inst_addr = csr_mepc[ADDR_W-1:0]. -> IDLE.
- Target address:
  - base = csr_mtvec with low 2 bits cleared.
  - If VECTORED=1 and mtvec[0]=1: target = base + 4*idx, modulo 2^ADDR_W (wraps, no error).
  - Otherwise target = base.
- hold_flag_int = 1 in SAV_ST, SAV_EPC, SAV_CAUSE and RET_ST. It is 0 in IDLE and in both ASSERT states.
- int_we is 0 outside the save/ret states. Data outputs hold their last value when int_we=0.
- While busy (not IDLE): ret_req is ignored, and pending keeps latching new edges.
- Masked or globally disabled interrupts stay pending indefinitely and are taken once enabled.
- Reset mid-sequence aborts immediately: no further int_we or int_assert, and pending is cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7.
  - INT_WE_MSTATUS/MEPC/MCAUSE one-hot constants.
  - MCAUSE_INT_BIT=DATA_W-1.
- One sub-module, int_prio_enc: parametrised lowest-index priority encoder producing valid and index.

Test Plan:
- Edge on int_req[5], int_en=0xFF, MIE=1, mtvec=0x0101, inst_addr=0x0040 -> int_we 001/010/100 on consecutive cycles; mepc=0x0040; mcause=0x8005; int_assert with int_inst_addr=0x0114; hold high exactly 3 cycles.
- Simultaneous edges on channels 2 and 6 -> channel 2 serviced first (mcause=0x8002, pending=0x40 afterwards); channel 6 serviced after the next IDLE cycle.
- Acceptance while jump_flag=1, jump_addr=0x0200 -> int_mepc=0x0200. With VECTORED=0 or mtvec=0x0100 -> target 0x0100 for any idx.
- MIE=0 or int_en[3]=0 with edge on channel 3 -> no int_we, pending[3] stays set. Enabling later triggers the sequence.
- ret_req and an eligible interrupt in the same IDLE cycle, with mstatus=0x0080 and mepc=0x0044 -> RET path first: int_mstatus=0x0088, then int_assert to 0x0044; the interrupt follows afterwards.
- rst_n=0 during SAV_EPC -> next cycle all outputs 0, pending 0, no int_assert. A held-high int_req does not retrigger without a new edge.
